// File: rtl/rd_arb_pkg.sv
// rd_arb_pkg: shared definitions for the DDR read-side arbiter.
//   state_t    - arbiter FSM encoding (IDLE/REQ/DATA/GAP)
//   NUM_CH     - number of video read channels served
//   CH_IDX_W   - width of a channel index
//   beat_width - beat width in bits for a given DQ width
package rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int NUM_CH   = 3;
  localparam int CH_IDX_W = 2;

  function automatic int beat_width(input int dq_width);
    return 8 * dq_width;
  endfunction

endpackage

// File: rtl/rd_arb_if.sv
// rd_arb_if: DDR controller read port.
//   ddr_rreq     - read request (arbiter -> controller)
//   ddr_raddr    - start address (arbiter -> controller)
//   ddr_rd_len   - burst length in beats (arbiter -> controller)
//   ddr_rrdy     - request accepted (controller -> arbiter)
//   ddr_rdata    - read beat (controller -> arbiter)
//   ddr_rdata_en - read beat valid (controller -> arbiter)
//   ddr_rdone    - burst complete (controller -> arbiter)
// Modports: master = arbiter side, slave = controller side.
interface rd_arb_if
  import rd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 32
);

  localparam int BEAT_W = beat_width(DQ_WIDTH);

  logic                  ddr_rreq;
  logic [ADDR_WIDTH-1:0] ddr_raddr;
  logic [LEN_WIDTH-1:0]  ddr_rd_len;
  logic                  ddr_rrdy;
  logic [BEAT_W-1:0]     ddr_rdata;
  logic                  ddr_rdata_en;
  logic                  ddr_rdone;

  modport master (
    output ddr_rreq, ddr_raddr, ddr_rd_len,
    input  ddr_rrdy, ddr_rdata, ddr_rdata_en, ddr_rdone
  );

  modport slave (
    input  ddr_rreq, ddr_raddr, ddr_rd_len,
    output ddr_rrdy, ddr_rdata, ddr_rdata_en, ddr_rdone
  );

endinterface

// File: rtl/rd_arb_pick.sv
// rd_arb_pick: combinational winner selection.
//   rreq      - per-channel request (bit0 = channel 1)
//   lvl1..3   - per-channel read-FIFO fill level
//   last      - index of the last granted channel
//   vld       - at least one channel is requesting
//   win       - index of the winning channel
// The lowest fill level wins; equal levels are resolved round-robin
// starting from the channel after 'last'.
module rd_arb_pick
  import rd_arb_pkg::*;
#(
  parameter int LVL_WIDTH = 6
) (
  input  logic [NUM_CH-1:0]   rreq,
  input  logic [LVL_WIDTH-1:0] lvl1,
  input  logic [LVL_WIDTH-1:0] lvl2,
  input  logic [LVL_WIDTH-1:0] lvl3,
  input  logic [CH_IDX_W-1:0] last,
  output logic                vld,
  output logic [CH_IDX_W-1:0] win
);

  logic [LVL_WIDTH-1:0] lvl [NUM_CH];
  logic [LVL_WIDTH-1:0] min_lvl;
  logic                 found;
  logic [CH_IDX_W-1:0]  idx;

  always_comb begin
    lvl[0]  = lvl1;
    lvl[1]  = lvl2;
    lvl[2]  = lvl3;
    min_lvl = '1;
    found   = 1'b0;
    vld     = 1'b0;
    win     = '0;
    idx     = '0;

    // Lowest level among requesters only; 'found' lets a level of all-ones win.
    for (int i = 0; i < NUM_CH; i++) begin
      if (rreq[i] && (!found || lvl[i] < min_lvl)) begin
        min_lvl = lvl[i];
        found   = 1'b1;
      end
    end

    // Round-robin scan beginning one past the last grant.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_IDX_W'((int'(last) + k) % NUM_CH);
      if (!vld && rreq[idx] && lvl[idx] == min_lvl) begin
        vld = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/rd_arb.sv
// rd_arb: DDR read-side arbiter for three video read channels.
//   ddr_clk, ddr_rst      - clock, synchronous active-high reset
//   ch_rreq               - per-channel read request (bit0 = channel 1)
//   ch_raddr1..3          - per-channel start address
//   ch_rd_len1..3         - per-channel burst length in beats
//   ch_lvl1..3            - per-channel read-FIFO fill level
//   ch_rgrant             - one-hot pulse when the request is accepted by DDR
//   ch_rdata, ch_rdata_en - registered read beat and one-hot beat strobe
//   ch_rdone              - one-hot pulse at burst completion
//   ddr                   - DDR controller read port (master side)
//   busy                  - FSM not in IDLE
//   beat_err              - sticky protocol/length error
module rd_arb
  import rd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16,
  parameter int DQ_WIDTH   = 32,
  parameter int LVL_WIDTH  = 6
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rst,
  input  logic [NUM_CH-1:0]     ch_rreq,
  input  logic [ADDR_WIDTH-1:0] ch_raddr1,
  input  logic [ADDR_WIDTH-1:0] ch_raddr2,
  input  logic [ADDR_WIDTH-1:0] ch_raddr3,
  input  logic [LEN_WIDTH-1:0]  ch_rd_len1,
  input  logic [LEN_WIDTH-1:0]  ch_rd_len2,
  input  logic [LEN_WIDTH-1:0]  ch_rd_len3,
  input  logic [LVL_WIDTH-1:0]  ch_lvl1,
  input  logic [LVL_WIDTH-1:0]  ch_lvl2,
  input  logic [LVL_WIDTH-1:0]  ch_lvl3,
  output logic [NUM_CH-1:0]     ch_rgrant,
  output logic [8*DQ_WIDTH-1:0] ch_rdata,
  output logic [NUM_CH-1:0]     ch_rdata_en,
  output logic [NUM_CH-1:0]     ch_rdone,
  rd_arb_if.master              ddr,
  output logic                  busy,
  output logic                  beat_err
);

  localparam int BEAT_W = beat_width(DQ_WIDTH);

  state_t                state_q, state_d;
  logic [CH_IDX_W-1:0]   win_q, win_d, last_q, last_d, pick_win;
  logic                  pick_vld;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pick_addr;
  logic [LEN_WIDTH-1:0]  len_q, len_d, pick_len;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                  zero_q, zero_d;
  logic                  rreq_q, rreq_d;
  logic                  err_q, err_d;
  logic                  stray;
  logic [NUM_CH-1:0]     win_oh;
  logic [NUM_CH-1:0]     grant_q, grant_d, done_q, done_d;
  logic [NUM_CH-1:0]     vld_p0, vld_p1;
  logic [BEAT_W-1:0]     rdata_p1;

  rd_arb_pick #(.LVL_WIDTH(LVL_WIDTH)) u_pick (
    .rreq (ch_rreq),
    .lvl1 (ch_lvl1),
    .lvl2 (ch_lvl2),
    .lvl3 (ch_lvl3),
    .last (last_q),
    .vld  (pick_vld),
    .win  (pick_win)
  );

  always_comb begin
    pick_addr = ch_raddr1;
    pick_len  = ch_rd_len1;
    case (pick_win)
      2'd1: begin
        pick_addr = ch_raddr2;
        pick_len  = ch_rd_len2;
      end
      2'd2: begin
        pick_addr = ch_raddr3;
        pick_len  = ch_rd_len3;
      end
      default: ;
    endcase
  end

  assign win_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << win_q;
  assign cnt_inc = cnt_q + LEN_WIDTH'(ddr.ddr_rdata_en);
  // Beats or completions outside a real burst (including a zero-length one).
  assign stray   = (ddr.ddr_rdata_en | ddr.ddr_rdone) & ((state_q != ST_DATA) | zero_q);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    rreq_d  = rreq_q;
    err_d   = err_q | stray;
    grant_d = '0;
    done_d  = '0;
    vld_p0  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_win;
          addr_d  = pick_addr;
          len_d   = pick_len;
          zero_d  = (pick_len == '0);
          rreq_d  = (pick_len != '0);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A zero-length request is granted locally without touching DDR.
        if (zero_q || ddr.ddr_rrdy) begin
          rreq_d  = 1'b0;
          grant_d = win_oh;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (zero_q) begin
          done_d  = win_oh;
          state_d = ST_GAP;
        end else begin
          if (ddr.ddr_rdata_en) begin
            vld_p0 = win_oh;
            cnt_d  = cnt_inc;
          end
          if (ddr.ddr_rdone) begin
            done_d  = win_oh;
            state_d = ST_GAP;
            if (cnt_inc != len_q) err_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        last_d  = win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: registered control, DDR request and forwarded beat.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      last_q   <= CH_IDX_W'(NUM_CH - 1);
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      rreq_q   <= 1'b0;
      err_q    <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      vld_p1   <= '0;
      rdata_p1 <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      rreq_q   <= rreq_d;
      err_q    <= err_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      vld_p1   <= vld_p0;
      rdata_p1 <= ddr.ddr_rdata;
    end
  end

  assign ddr.ddr_rreq   = rreq_q;
  assign ddr.ddr_raddr  = addr_q;
  assign ddr.ddr_rd_len = len_q;
  assign ch_rgrant      = grant_q;
  assign ch_rdone       = done_q;
  assign ch_rdata_en    = vld_p1;
  assign ch_rdata       = rdata_p1;
  assign busy           = (state_q != ST_IDLE);
  assign beat_err       = err_q;

endmodule

// File: tb/tb_rd_arb.sv
module tb_rd_arb;

  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DQ = 32;
  localparam int VW = 6;
  localparam int BW = 8 * DQ;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst = 1'b1;
  logic [2:0]    ch_rreq = '0;
  logic [AW-1:0] ch_raddr1 = '0, ch_raddr2 = '0, ch_raddr3 = '0;
  logic [LW-1:0] ch_rd_len1 = '0, ch_rd_len2 = '0, ch_rd_len3 = '0;
  logic [VW-1:0] ch_lvl1 = '0, ch_lvl2 = '0, ch_lvl3 = '0;
  logic [2:0]    ch_rgrant, ch_rdata_en, ch_rdone;
  logic [BW-1:0] ch_rdata;
  logic          busy, beat_err;

  int checks   = 0;
  int failures = 0;

  logic [2:0]    gq[$];
  logic [2:0]    dq[$];
  logic [2:0]    bchq[$];
  logic [BW-1:0] bq[$];

  rd_arb_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQ)) ddr_if ();

  rd_arb #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQ), .LVL_WIDTH(VW)) dut (
    .ddr_clk     (ddr_clk),
    .ddr_rst     (ddr_rst),
    .ch_rreq     (ch_rreq),
    .ch_raddr1   (ch_raddr1),
    .ch_raddr2   (ch_raddr2),
    .ch_raddr3   (ch_raddr3),
    .ch_rd_len1  (ch_rd_len1),
    .ch_rd_len2  (ch_rd_len2),
    .ch_rd_len3  (ch_rd_len3),
    .ch_lvl1     (ch_lvl1),
    .ch_lvl2     (ch_lvl2),
    .ch_lvl3     (ch_lvl3),
    .ch_rgrant   (ch_rgrant),
    .ch_rdata    (ch_rdata),
    .ch_rdata_en (ch_rdata_en),
    .ch_rdone    (ch_rdone),
    .ddr         (ddr_if),
    .busy        (busy),
    .beat_err    (beat_err)
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge ddr_clk);
    #1;
  endtask

  // Scoreboard: every grant, beat and done must match the next queued expectation.
  always @(negedge ddr_clk) begin
    if (ch_rgrant != '0) begin
      if (gq.size() == 0) chk("mon_grant_unexpected", BW'(ch_rgrant), BW'(3'b000));
      else                chk("mon_grant", BW'(ch_rgrant), BW'(gq.pop_front()));
    end
    if (ch_rdata_en != '0) begin
      if (bq.size() == 0) chk("mon_beat_unexpected", BW'(ch_rdata_en), BW'(3'b000));
      else begin
        chk("mon_beat_ch", BW'(ch_rdata_en), BW'(bchq.pop_front()));
        chk("mon_beat_data", ch_rdata, bq.pop_front());
      end
    end
    if (ch_rdone != '0) begin
      if (dq.size() == 0) chk("mon_done_unexpected", BW'(ch_rdone), BW'(3'b000));
      else                chk("mon_done", BW'(ch_rdone), BW'(dq.pop_front()));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   BW'(ch_rgrant),          '0);
    chk({tag, "_rdata"},   ch_rdata,                '0);
    chk({tag, "_rdata_en"},BW'(ch_rdata_en),        '0);
    chk({tag, "_rdone"},   BW'(ch_rdone),           '0);
    chk({tag, "_ddr_rreq"},BW'(ddr_if.ddr_rreq),    '0);
    chk({tag, "_raddr"},   BW'(ddr_if.ddr_raddr),   '0);
    chk({tag, "_rd_len"},  BW'(ddr_if.ddr_rd_len),  '0);
    chk({tag, "_busy"},    BW'(busy),               '0);
    chk({tag, "_beat_err"},BW'(beat_err),           '0);
  endtask

  task automatic do_reset();
    ddr_rst = 1'b1;
    ch_rreq = '0;
    ddr_if.ddr_rdata = '0;
    step();
    ddr_rst = 1'b0;
  endtask

  // One complete transaction, called in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_txn(input logic [2:0] rreq, input logic [VW-1:0] l1, l2, l3,
                         input logic [LW-1:0] n1, n2, n3, input logic [AW-1:0] base,
                         input int exp_ch, input int rdly, input int nbeats, input string tag);
    logic [2:0]    oh;
    logic [LW-1:0] exp_len;
    logic [BW-1:0] d;
    oh      = 3'(3'b001 << (exp_ch - 1));
    exp_len = (exp_ch == 1) ? n1 : (exp_ch == 2) ? n2 : n3;
    ch_rreq = rreq;
    ch_lvl1 = l1; ch_lvl2 = l2; ch_lvl3 = l3;
    ch_rd_len1 = n1; ch_rd_len2 = n2; ch_rd_len3 = n3;
    ch_raddr1 = base + AW'(1); ch_raddr2 = base + AW'(2); ch_raddr3 = base + AW'(3);
    gq.push_back(oh);
    step();
    chk({tag, "_rreq_up"}, BW'(ddr_if.ddr_rreq),  BW'(1'b1));
    chk({tag, "_raddr"},   BW'(ddr_if.ddr_raddr), BW'(base + AW'(exp_ch)));
    chk({tag, "_rd_len"},  BW'(ddr_if.ddr_rd_len),BW'(exp_len));
    chk({tag, "_busy"},    BW'(busy),             BW'(1'b1));
    for (int i = 0; i < rdly; i++) step();
    chk({tag, "_rreq_hold"}, BW'(ddr_if.ddr_rreq), BW'(1'b1));
    ddr_if.ddr_rrdy = 1'b1;
    step();
    ddr_if.ddr_rrdy = 1'b0;
    chk({tag, "_rreq_down"}, BW'(ddr_if.ddr_rreq), BW'(1'b0));
    chk({tag, "_grant"},     BW'(ch_rgrant),       BW'(oh));
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < BW / 32; k++) d[32*k +: 32] = $urandom;
      ddr_if.ddr_rdata_en = 1'b1;
      ddr_if.ddr_rdata    = d;
      ddr_if.ddr_rdone    = (b == nbeats - 1);
      bq.push_back(d);
      bchq.push_back(oh);
      if (b == nbeats - 1) dq.push_back(oh);
      step();
      chk({tag, "_beat_lat"}, BW'(ch_rdata_en), BW'(oh));
    end
    ddr_if.ddr_rdata_en = 1'b0;
    ddr_if.ddr_rdone    = 1'b0;
    chk({tag, "_done_lat"}, BW'(ch_rdone), BW'(oh));
    step();
    chk({tag, "_idle"}, BW'(busy), BW'(1'b0));
  endtask

  typedef struct {
    bit            rst_b;
    logic [2:0]    rreq;
    logic [VW-1:0] l1, l2, l3;
    logic [LW-1:0] n1, n2, n3;
    int            exp_ch;
    int            rdly;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [LW-1:0] elen;
    logic [BW-1:0] d;

    vecs[0]  = '{1'b0, 3'b001, 6'd10, 6'd10, 6'd10, 16'd4, 16'd1, 16'd1, 1, 2};
    vecs[1]  = '{1'b0, 3'b111, 6'd20, 6'd5,  6'd12, 16'd2, 16'd3, 16'd1, 2, 1};
    vecs[2]  = '{1'b0, 3'b101, 6'd20, 6'd5,  6'd12, 16'd2, 16'd3, 16'd1, 3, 0};
    vecs[3]  = '{1'b0, 3'b001, 6'd20, 6'd5,  6'd12, 16'd2, 16'd3, 16'd1, 1, 0};
    vecs[4]  = '{1'b1, 3'b111, 6'd7,  6'd7,  6'd7,  16'd1, 16'd2, 16'd3, 1, 0};
    vecs[5]  = '{1'b0, 3'b111, 6'd7,  6'd7,  6'd7,  16'd1, 16'd2, 16'd3, 2, 1};
    vecs[6]  = '{1'b0, 3'b111, 6'd7,  6'd7,  6'd7,  16'd1, 16'd2, 16'd3, 3, 0};
    vecs[7]  = '{1'b0, 3'b111, 6'd7,  6'd7,  6'd7,  16'd1, 16'd2, 16'd3, 1, 2};
    vecs[8]  = '{1'b0, 3'b111, 6'd7,  6'd7,  6'd7,  16'd1, 16'd2, 16'd3, 2, 0};
    vecs[9]  = '{1'b0, 3'b111, 6'd7,  6'd7,  6'd7,  16'd1, 16'd2, 16'd3, 3, 3};
    vecs[10] = '{1'b0, 3'b111, 6'd3,  6'd9,  6'd3,  16'd2, 16'd2, 16'd2, 1, 0};
    vecs[11] = '{1'b0, 3'b111, 6'd3,  6'd9,  6'd3,  16'd2, 16'd2, 16'd2, 3, 0};
    vecs[12] = '{1'b0, 3'b111, 6'd3,  6'd9,  6'd3,  16'd2, 16'd2, 16'd2, 1, 1};
    vecs[13] = '{1'b0, 3'b010, 6'd0,  6'd63, 6'd0,  16'd1, 16'd5, 16'd1, 2, 0};

    ddr_if.ddr_rrdy     = 1'b0;
    ddr_if.ddr_rdata    = '0;
    ddr_if.ddr_rdata_en = 1'b0;
    ddr_if.ddr_rdone    = 1'b0;

    ddr_rst = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    ddr_rst = 1'b0;

    // Table-driven arbitration: single request, level priority, round-robin ties.
    foreach (vecs[i]) begin
      if (vecs[i].rst_b) do_reset();
      elen = (vecs[i].exp_ch == 1) ? vecs[i].n1 : (vecs[i].exp_ch == 2) ? vecs[i].n2 : vecs[i].n3;
      run_txn(vecs[i].rreq, vecs[i].l1, vecs[i].l2, vecs[i].l3,
              vecs[i].n1, vecs[i].n2, vecs[i].n3, AW'(i * 16), vecs[i].exp_ch,
              vecs[i].rdly, int'(elen), $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_beat_err", i), BW'(beat_err), BW'(1'b0));
    end
    ch_rreq = '0;

    // Zero-length request, then a stray beat in IDLE.
    ch_rreq = 3'b010; ch_rd_len2 = '0; ch_lvl2 = 6'd4;
    gq.push_back(3'b010);
    dq.push_back(3'b010);
    step();
    chk("zero_no_rreq_req", BW'(ddr_if.ddr_rreq), BW'(1'b0));
    chk("zero_busy",        BW'(busy),            BW'(1'b1));
    step();
    chk("zero_grant",       BW'(ch_rgrant),       BW'(3'b010));
    chk("zero_no_rreq_data",BW'(ddr_if.ddr_rreq), BW'(1'b0));
    ch_rreq = '0;
    step();
    chk("zero_done",        BW'(ch_rdone),        BW'(3'b010));
    step();
    chk("zero_idle",        BW'(busy),            BW'(1'b0));
    chk("zero_err_clear",   BW'(beat_err),        BW'(1'b0));
    ddr_if.ddr_rdata_en = 1'b1;
    ddr_if.ddr_rdata    = {(BW/32){32'hdeadbeef}};
    step();
    ddr_if.ddr_rdata_en = 1'b0;
    chk("stray_no_fwd",     BW'(ch_rdata_en),     BW'(3'b000));
    chk("stray_err",        BW'(beat_err),        BW'(1'b1));
    step();

    // Length mismatch: 7 beats against a length of 8; the flag is sticky.
    do_reset();
    chk("mis_err_pre", BW'(beat_err), BW'(1'b0));
    run_txn(3'b001, 6'd1, 6'd1, 6'd1, 16'd8, 16'd8, 16'd8, AW'(32'h100), 1, 1, 7, "mis");
    chk("mis_err_set", BW'(beat_err), BW'(1'b1));
    run_txn(3'b010, 6'd1, 6'd1, 6'd1, 16'd2, 16'd2, 16'd2, AW'(32'h200), 2, 0, 2, "mis_next");
    chk("mis_err_sticky", BW'(beat_err), BW'(1'b1));
    ch_rreq = '0;
    do_reset();
    chk("mis_err_cleared", BW'(beat_err), BW'(1'b0));

    // Reset in the middle of a burst.
    ch_rreq = 3'b100; ch_rd_len3 = 16'd4; ch_lvl3 = 6'd2; ch_raddr3 = AW'(32'h333);
    gq.push_back(3'b100);
    step();
    ddr_if.ddr_rrdy = 1'b1;
    step();
    ddr_if.ddr_rrdy = 1'b0;
    ch_rreq = '0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < BW / 32; k++) d[32*k +: 32] = $urandom;
      ddr_if.ddr_rdata_en = 1'b1;
      ddr_if.ddr_rdata    = d;
      bq.push_back(d);
      bchq.push_back(3'b100);
      step();
    end
    ddr_if.ddr_rdata_en = 1'b0;
    ddr_if.ddr_rdata    = '0;
    ddr_rst = 1'b1;
    step();
    ddr_rst = 1'b0;
    chk_all_zero("midrst");
    repeat (4) step();
    chk("midrst_idle", BW'(busy), BW'(1'b0));
    chk("midrst_no_done", BW'(ch_rdone), BW'(3'b000));

    repeat (3) step();
    chk("sb_grant_drained", BW'(gq.size()), '0);
    chk("sb_beat_drained",  BW'(bq.size()), '0);
    chk("sb_done_drained",  BW'(dq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
